// File: rtl/miriscv_dmem_resp.sv
// miriscv_dmem_resp: data-memory responder for the core's LSU.
// This is a word-organised, byte-writable synchronous RAM. Read data is registered, so it
// is valid one cycle after the request. Out-of-range accesses raise a sticky error flag
// and capture the address of the first bad access.
// Optional feature: define MIRISCV_DMEM_ACCESS_CNT_EN to add the read/write access
// counters rd_cnt_o and wr_cnt_o.
module miriscv_dmem_resp #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic        err_clr_i,
    output logic [31:0] data_rdata_o,
    output logic        err_o,
`ifdef MIRISCV_DMEM_ACCESS_CNT_EN
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o,
`endif
    output logic [31:0] err_addr_o
);

    localparam int unsigned AW    = $clog2(RAM_WORDS);
    localparam logic [32:0] LIMIT = 33'(RAM_WORDS) << 2;

    typedef enum logic {
        StIdle,
        StResp
    } state_e;

    state_e      r_state;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_err_addr;
    logic [31:0] r_mem [RAM_WORDS];

    logic [31:0]   w_offset;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_accept;
    logic          w_bad;

    // Address decode. An address below BASE_ADDR wraps to a huge offset and is out of range.
    always_comb begin
        w_offset   = data_addr_i - BASE_ADDR;
        w_in_range = ({1'b0, w_offset} < LIMIT);
        w_idx      = w_offset[AW+1:2];
        // Only IDLE accepts. A request seen in RESP is the stall continuation of the same access.
        w_accept   = (r_state == StIdle) && data_req_i && !rst_i;
        w_bad      = w_accept && !w_in_range;
    end

    // Byte-lane RAM write. The contents are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (w_accept && data_we_i && w_in_range) begin
            for (int n = 0; n < 4; n++) begin
                if (data_be_i[n]) begin
                    r_mem[w_idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
                end
            end
        end
    end

    // Request/response FSM with registered read data and sticky error capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= StIdle;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
            r_err_addr <= 32'h0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (data_req_i) begin
                        r_state <= StResp;
                        if (!data_we_i) begin
                            r_rdata <= w_in_range ? r_mem[w_idx] : 32'h0;
                        end
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase

            // A new bad access beats a simultaneous clear. Otherwise the first error wins.
            if (w_bad && (!r_err || err_clr_i)) begin
                r_err      <= 1'b1;
                r_err_addr <= data_addr_i;
            end else if (err_clr_i) begin
                r_err      <= 1'b0;
                r_err_addr <= 32'h0;
            end
        end
    end

`ifdef MIRISCV_DMEM_ACCESS_CNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    // Count accepted accesses of each type, out-of-range ones included. The counters wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_cnt <= 32'h0;
            r_wr_cnt <= 32'h0;
        end else if (w_accept) begin
            if (data_we_i) begin
                r_wr_cnt <= r_wr_cnt + 32'h1;
            end else begin
                r_rd_cnt <= r_rd_cnt + 32'h1;
            end
        end
    end

    assign rd_cnt_o = r_rd_cnt;
    assign wr_cnt_o = r_wr_cnt;
`endif

    assign data_rdata_o = r_rdata;
    assign err_o        = r_err;
    assign err_addr_o   = r_err_addr;

endmodule
